// File: rtl/rename_unit_pkg.sv
// Shared constants and types for the rename stage.
package rename_unit_pkg;

   localparam int NUM_TAGS_LOG2 = 6;
   localparam int ROB_SIZE_LOG2 = 5;
   localparam int REG_SIZE      = 5;

   typedef logic [NUM_TAGS_LOG2-1:0] tag_t;
   typedef logic [ROB_SIZE_LOG2-1:0] rob_idx_t;
   typedef logic [REG_SIZE-1:0]      areg_t;

endpackage

// File: rtl/free_list_fifo.sv
// Circular free-tag list; entries FILL_LO..DEPTH-1 hold their own index after reset, head at FILL_LO.
// Pop is gated by the registered count, so a tag pushed this cycle is only poppable next cycle.
module free_list_fifo #(
   parameter int DEPTH   = 64,
   parameter int FILL_LO = 32,
   localparam int W      = $clog2(DEPTH),
   localparam int CW     = $clog2(DEPTH + 1)
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         push,
   input  logic [W-1:0] push_tag,
   input  logic         pop,
   output logic [W-1:0] pop_tag,
   output logic         empty
);

   logic [W-1:0]  mem [DEPTH];
   logic [W-1:0]  head;
   logic [W-1:0]  tail;
   logic [CW-1:0] count;
   logic          push_ok;
   logic          pop_ok;

   function automatic logic [W-1:0] ptr_inc(input logic [W-1:0] p);
      return (p == W'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   assign empty   = (count == '0);
   assign pop_tag = mem[head];
   assign pop_ok  = pop && !empty;
   assign push_ok = push && (count != CW'(DEPTH));

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= W'(i);
         head  <= W'(FILL_LO % DEPTH);
         tail  <= '0;
         count <= CW'(DEPTH - FILL_LO);
      end else begin
         if (push_ok) begin
            mem[tail] <= push_tag;
            tail      <= ptr_inc(tail);
         end
         if (pop_ok) head <= ptr_inc(head);
         case ({push_ok, pop_ok})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/rename_unit.sv
// Register rename: RAT lookup, free-list allocation, busy tracking; outputs registered 1 cycle after acceptance.
// Stalls decode on stall_in or an empty free list; RENAME_CDB_BYPASS_EN forwards same-cycle CDB wakeups into ready_rs.
module rename_unit
   import rename_unit_pkg::*;
#(
   parameter int NUM_TAGS    = 1 << NUM_TAGS_LOG2,
   parameter int ARCH_REGS   = 32,
   parameter int ISSUE_PORTS = 3,
   localparam int TW         = $clog2(NUM_TAGS)
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                stall_in,
   input  logic                in_valid,
   input  logic [REG_SIZE-1:0] rd,
   input  logic [REG_SIZE-1:0] rs1,
   input  logic [REG_SIZE-1:0] rs2,
   input  logic                rd_we,
   input  logic [TW-1:0]       cdb_tags [0:ISSUE_PORTS-1],
   input  logic                cdb_valid [0:ISSUE_PORTS-1],
   input  logic                retire_valid,
   input  logic [TW-1:0]       retire_old_tag,
   output logic                out_valid,
   output logic [TW-1:0]       tag_rd,
   output logic [TW-1:0]       tag_rs1,
   output logic [TW-1:0]       tag_rs2,
   output logic [TW-1:0]       old_tag_rd,
   output logic                ready_rs [0:1],
   output logic                rn_stall
);

   logic [TW-1:0]       rat [ARCH_REGS];
   logic [NUM_TAGS-1:0] busy;

   logic                alloc_need;
   logic                accept;
   logic                do_alloc;
   logic                fl_empty;
   logic [TW-1:0]       fl_head;
   logic                fl_push;

   logic [REG_SIZE-1:0] src_idx [2];
   logic [TW-1:0]       src_tag [2];
   logic                src_rdy [2];

   assign alloc_need = in_valid && rd_we && (rd != '0);
   assign rn_stall   = stall_in || (alloc_need && fl_empty);
   assign accept     = in_valid && !rn_stall;
   assign do_alloc   = accept && alloc_need;
   // Tag 0 is the permanent x0 mapping and never re-enters the list.
   assign fl_push    = retire_valid && (retire_old_tag != '0);

   free_list_fifo #(
      .DEPTH   (NUM_TAGS),
      .FILL_LO (ARCH_REGS)
   ) u_free_list (
      .clk      (clk),
      .rst      (rst),
      .push     (fl_push),
      .push_tag (retire_old_tag),
      .pop      (do_alloc),
      .pop_tag  (fl_head),
      .empty    (fl_empty)
   );

   assign src_idx[0] = rs1;
   assign src_idx[1] = rs2;

   // Sources read the RAT before this cycle's rd update, so rs == rd sees the old mapping.
   always_comb begin
      for (int s = 0; s < 2; s++) begin
         src_tag[s] = '0;
         src_rdy[s] = 1'b1;
         if (src_idx[s] != '0) begin
            src_tag[s] = rat[src_idx[s]];
            src_rdy[s] = !busy[src_tag[s]];
`ifdef RENAME_CDB_BYPASS_EN
            for (int p = 0; p < ISSUE_PORTS; p++) begin
               if (cdb_valid[p] && (cdb_tags[p] == src_tag[s])) src_rdy[s] = 1'b1;
            end
`endif
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int r = 0; r < ARCH_REGS; r++) rat[r] <= TW'(r);
      end else if (do_alloc) begin
         rat[rd] <= fl_head;
      end
   end

   // Allocation set follows the CDB clears so a fresh tag always ends up busy.
   always_ff @(posedge clk) begin
      if (rst) begin
         busy <= '0;
      end else begin
         for (int p = 0; p < ISSUE_PORTS; p++) begin
            if (cdb_valid[p]) busy[cdb_tags[p]] <= 1'b0;
         end
         if (do_alloc) busy[fl_head] <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid   <= 1'b0;
         tag_rd      <= '0;
         tag_rs1     <= '0;
         tag_rs2     <= '0;
         old_tag_rd  <= '0;
         ready_rs[0] <= 1'b0;
         ready_rs[1] <= 1'b0;
      end else if (!stall_in) begin
         out_valid <= accept;
         if (accept) begin
            tag_rs1     <= src_tag[0];
            tag_rs2     <= src_tag[1];
            ready_rs[0] <= src_rdy[0];
            ready_rs[1] <= src_rdy[1];
            tag_rd      <= do_alloc ? fl_head : '0;
            old_tag_rd  <= do_alloc ? rat[rd] : '0;
         end
      end
   end

endmodule

// File: doc/rename_unit.md
RENAME_UNIT -- requirements
Module: rename_unit

Interface
REQ-001 The module SHALL have parameter NUM_TAGS, default 64, giving the physical tag count; tag width TW = $clog2(NUM_TAGS).
REQ-002 The module SHALL have parameter ARCH_REGS, default 32, giving the architectural register count; index width 5.
REQ-003 The module SHALL have parameter ISSUE_PORTS, default 3, giving the number of CDB broadcast ports.
REQ-004 The module SHALL have the port clk, input, 1 bit, the clock.
REQ-005 The module SHALL have the port rst, input, 1 bit, the reset: synchronous, active-high.
REQ-006 The module SHALL have the port stall_in, input, 1 bit, the downstream issue-queue stall.
REQ-007 The module SHALL have the port in_valid, input, 1 bit, meaning a decoded instruction is present.
REQ-008 The module SHALL have the ports rd, rs1 and rs2, input, 5 bits each, the architectural destination and source indices.
REQ-009 The module SHALL have the port rd_we, input, 1 bit, meaning the instruction writes rd.
REQ-010 The module SHALL have the ports cdb_tags [0:ISSUE_PORTS-1] (input, TW bits each) and cdb_valid [0:ISSUE_PORTS-1] (input, 1 bit each), carrying completion broadcasts.
REQ-011 The module SHALL have the ports retire_valid (input, 1 bit) and retire_old_tag (input, TW bits), returning a freed tag from the ROB.
REQ-012 The module SHALL have the port out_valid, output, 1 bit, meaning a renamed instruction is present.
REQ-013 The module SHALL have the ports tag_rd, tag_rs1 and tag_rs2, output, TW bits each, the physical tags.
REQ-014 The module SHALL have the port old_tag_rd, output, TW bits, the previous mapping of rd, sent to the ROB.
REQ-015 The module SHALL have the port ready_rs [0:1], output, 1 bit each, meaning the source value is available.
REQ-016 The module SHALL have the port rn_stall, output, 1 bit, the back-pressure to decode.

Function
REQ-017 The unit SHALL contain a RAT (ARCH_REGS x TW), a free-list FIFO (NUM_TAGS entries with head, tail and count), and a busy vector (NUM_TAGS bits).
REQ-018 alloc_need SHALL equal in_valid & rd_we & (rd != 0).
REQ-019 rn_stall SHALL equal stall_in | (alloc_need & free_count == 0), computed combinationally.
REQ-020 An instruction SHALL be accepted when in_valid & !rn_stall; decode holds its inputs while rn_stall is high.
REQ-021 Outputs SHALL be registered, with 1-cycle latency from acceptance.
REQ-022 While stall_in is high, all outputs SHALL hold their values.
REQ-023 If stall_in is low and no instruction is accepted, out_valid SHALL go to 0.
REQ-024 Source tags SHALL be read from the RAT before the same-cycle rd update, so rs1 == rd returns the old mapping.
REQ-025 An index of 0 SHALL always yield tag 0 with ready = 1.
REQ-026 On acceptance with alloc_need, tag_rd SHALL be taken from the free-list head, the RAT[rd] entry updated, busy[tag] set, and old_tag_rd set to the prior RAT[rd].
REQ-027 On acceptance without alloc_need, tag_rd and old_tag_rd SHALL be 0 and no list pop SHALL occur.
REQ-028 ready_rs[i] SHALL equal !busy[tag_rs_i].
REQ-029 Each cdb_valid[p] SHALL clear busy[cdb_tags[p]] at the clock edge.
REQ-030 The free list SHALL be pushed with retire_old_tag when retire_valid is high and retire_old_tag != 0.
REQ-031 A push and a pop SHALL be allowed in the same cycle; the count SHALL be unchanged.
REQ-032 A tag pushed in cycle N SHALL NOT be poppable until cycle N+1; an empty list plus a same-cycle push SHALL still stall.
REQ-033 The head and tail pointers SHALL wrap modulo NUM_TAGS.
REQ-034 A push when the list is full SHALL be ignored.

Reset
REQ-035 On reset, the RAT SHALL be set to identity (r -> tag r).
REQ-036 On reset, the free list SHALL hold tags ARCH_REGS..NUM_TAGS-1 in ascending order, with head at tag ARCH_REGS and count = NUM_TAGS-ARCH_REGS.
REQ-037 On reset, the busy vector SHALL be all 0.
REQ-038 On reset, out_valid, all tag outputs and ready_rs SHALL be 0.
REQ-039 Reset SHALL take priority over all other events; an in-flight instruction is discarded.

Configuration
REQ-040 With macro RENAME_CDB_BYPASS_EN defined, ready_rs[i] SHALL also be 1 when tag_rs_i matches any cdb_valid tag in the acceptance cycle.
REQ-041 Without RENAME_CDB_BYPASS_EN, ready_rs[i] SHALL reflect only the busy vector as registered before that edge.

Structure
REQ-042 NUM_TAGS_LOG2, ROB_SIZE_LOG2 and REG_SIZE SHALL come from the shared constants package.
REQ-043 The shared package SHALL define the typedef tag_t.
REQ-044 The free list SHALL be a sub-module named free_list_fifo, parameterised by depth and reset fill.

Verification
REQ-045 Bench SHALL apply reset, then rename add x5,x1,x2 -> tag_rd=32, tag_rs1=1, tag_rs2=2, ready_rs={1,1}, old_tag_rd=5.
REQ-046 Bench SHALL apply back-to-back x5 writes then a read of x5 -> second tag_rd=33 with old_tag_rd=32; the reader gets tag_rs1=33 with ready=0.
REQ-047 Bench SHALL broadcast cdb tag 33 and then rename a reader of x5 -> ready_rs[0]=1; with bypass, ready=1 when the broadcast is in the same cycle.
REQ-048 Bench SHALL allocate 32 tags -> rn_stall=1 on the 33rd; a retire of tag 7 -> the stall clears the next cycle and tag_rd=7.
REQ-049 Bench SHALL assert stall_in for 3 cycles -> outputs hold and no pop occurs; rd=0 -> tag_rd=0 and free_count unchanged.
REQ-050 Bench SHALL assert rst mid-stream -> next cycle out_valid=0, the RAT is identity, and the next allocation returns 32.
